// File: rtl/feed_schedule_ctrl.sv
// Feed-time slot store with browse/edit UI, display source select and feeder req/ack handshake.
// Define FEED_COUNT_EN to add the saturating feed_count output.
module feed_schedule_ctrl #(
   parameter int NUM_SLOTS    = 4,
   parameter int BLINK_CYCLES = 12500000,
   parameter int ACK_TIMEOUT  = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cur_hour,
   input  logic [7:0] cur_minute,
   input  logic       cur_ampm,
   input  logic       min_tick,
   input  logic       btn_edit,
   input  logic       btn_next,
   input  logic       btn_hour,
   input  logic       btn_min,
   input  logic       btn_ampm,
   input  logic       btn_clear,
   input  logic       feed_ack,
   output logic [7:0] disp_hour,
   output logic [7:0] disp_minute,
   output logic       disp_ampm,
   output logic [2:0] disp_slot,
   output logic       editing,
   output logic       blink,
   output logic       feed_req,
`ifdef FEED_COUNT_EN
   output logic [7:0] feed_count,
`endif
   output logic       feed_fault
);

   localparam int SW = $clog2(NUM_SLOTS);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
   localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BROWSE = 2'd1, ST_EDIT = 2'd2, ST_FEED = 2'd3} state_t;

   state_t        r_state, w_nxt_state;
   logic [SW-1:0] r_sel, w_nxt_sel, w_match_idx;
   logic [7:0]    r_slot_hour [NUM_SLOTS];
   logic [7:0]    r_slot_min  [NUM_SLOTS];
   logic          r_slot_ampm [NUM_SLOTS];
   logic [7:0]    w_sel_hour, w_sel_min, w_ed_hour, w_ed_min;
   logic          w_sel_ampm, w_ed_ampm, w_sel_empty, w_match, w_feed_go;
   logic          w_wr_en, w_fault_set, w_fault_clr;
   logic [7:0]    w_disp_hour, w_disp_min, r_disp_hour, r_disp_min;
   logic          w_disp_ampm, r_disp_ampm;
   logic [2:0]    w_disp_slot, r_disp_slot;
   logic [TW-1:0] r_to_cnt;
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink, r_fault, r_feed_req, r_editing;

   assign w_sel_hour  = r_slot_hour[r_sel];
   assign w_sel_min   = r_slot_min[r_sel];
   assign w_sel_ampm  = r_slot_ampm[r_sel];
   assign w_sel_empty = (w_sel_hour == 8'd0) && (w_sel_min == 8'd0);

   // Lowest-index non-empty slot equal to the live time
   always_comb begin
      w_match     = 1'b0;
      w_match_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if ((r_slot_hour[i] != 8'd0) && (r_slot_hour[i] == cur_hour) &&
             (r_slot_min[i] == cur_minute) && (r_slot_ampm[i] == cur_ampm)) begin
            w_match     = 1'b1;
            w_match_idx = SW'(i);
         end else begin
            w_match = w_match;
         end
      end
   end

   assign w_feed_go = min_tick && w_match && ((r_state == ST_IDLE) || (r_state == ST_BROWSE));

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_nxt_state;
   end

   // Next state, selection and slot edit decode; a matching tick overrides any button
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_sel   = r_sel;
      w_wr_en     = 1'b0;
      w_ed_hour   = w_sel_hour;
      w_ed_min    = w_sel_min;
      w_ed_ampm   = w_sel_ampm;
      w_fault_set = 1'b0;
      w_fault_clr = 1'b0;
      if (w_feed_go) begin
         w_nxt_state = ST_FEED;
         w_nxt_sel   = w_match_idx;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (btn_edit) begin
                  w_nxt_state = ST_BROWSE;
                  w_nxt_sel   = '0;
               end else if (btn_clear) begin
                  w_fault_clr = 1'b1;
               end else begin
                  w_nxt_state = ST_IDLE;
               end
            end
            ST_BROWSE: begin
               if (btn_edit) begin
                  w_nxt_state = ST_EDIT;
               end else if (btn_clear) begin
                  w_wr_en = 1'b1; w_ed_hour = 8'd0; w_ed_min = 8'd0; w_ed_ampm = 1'b0;
               end else if (btn_next) begin
                  if (r_sel == LAST_SLOT) begin
                     w_nxt_state = ST_IDLE;
                     w_nxt_sel   = '0;
                  end else begin
                     w_nxt_sel = r_sel + SW'(1);
                  end
               end else begin
                  w_nxt_state = ST_BROWSE;
               end
            end
            ST_EDIT: begin
               if (btn_edit) begin
                  w_nxt_state = ST_BROWSE;
               end else if (btn_clear) begin
                  w_wr_en = 1'b1; w_ed_hour = 8'd0; w_ed_min = 8'd0; w_ed_ampm = 1'b0;
               end else if (btn_next) begin
                  w_nxt_state = ST_EDIT;
               end else if (btn_hour) begin
                  w_wr_en   = 1'b1;
                  w_ed_hour = ((w_sel_hour == 8'd0) || (w_sel_hour == 8'd12)) ? 8'd1 : w_sel_hour + 8'd1;
               end else if (btn_min) begin
                  w_wr_en = 1'b1;
                  if (w_sel_empty) begin
                     w_ed_hour = 8'd12; w_ed_min = 8'd1; w_ed_ampm = 1'b1;
                  end else begin
                     w_ed_min = (w_sel_min == 8'd59) ? 8'd0 : w_sel_min + 8'd1;
                  end
               end else if (btn_ampm) begin
                  w_wr_en = 1'b1;
                  if (w_sel_empty) begin
                     w_ed_hour = 8'd12; w_ed_min = 8'd0; w_ed_ampm = 1'b0;
                  end else begin
                     w_ed_ampm = ~w_sel_ampm;
                  end
               end else begin
                  w_nxt_state = ST_EDIT;
               end
            end
            ST_FEED: begin
               if (feed_ack) begin
                  w_nxt_state = ST_IDLE;
                  w_nxt_sel   = '0;
               end else if (r_to_cnt == TO_LAST) begin
                  w_nxt_state = ST_IDLE;
                  w_nxt_sel   = '0;
                  w_fault_set = 1'b1;
               end else begin
                  w_nxt_state = ST_FEED;
               end
            end
            default: begin
               w_nxt_state = ST_IDLE;
               w_nxt_sel   = '0;
            end
         endcase
      end
   end

   // Display source for the upcoming state; a slot being written shows its new value
   always_comb begin
      w_disp_hour = cur_hour;
      w_disp_min  = cur_minute;
      w_disp_ampm = cur_ampm;
      w_disp_slot = 3'd0;
      case (w_nxt_state)
         ST_BROWSE, ST_EDIT: begin
            w_disp_slot = 3'(w_nxt_sel);
            if (w_wr_en) begin
               w_disp_hour = w_ed_hour; w_disp_min = w_ed_min; w_disp_ampm = w_ed_ampm;
            end else begin
               w_disp_hour = r_slot_hour[w_nxt_sel];
               w_disp_min  = r_slot_min[w_nxt_sel];
               w_disp_ampm = r_slot_ampm[w_nxt_sel];
            end
         end
         ST_FEED: w_disp_slot = 3'(w_nxt_sel);
         default: w_disp_slot = 3'd0;
      endcase
   end

   // Slot store, timers, fault flag and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sel <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_slot_hour[i] <= 8'd0;
            r_slot_min[i]  <= 8'd0;
            r_slot_ampm[i] <= 1'b0;
         end
         r_to_cnt    <= '0;
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
         r_fault     <= 1'b0;
         r_feed_req  <= 1'b0;
         r_editing   <= 1'b0;
         r_disp_hour <= cur_hour;
         r_disp_min  <= cur_minute;
         r_disp_ampm <= cur_ampm;
         r_disp_slot <= 3'd0;
      end else begin
         r_sel <= w_nxt_sel;
         if (w_wr_en) begin
            r_slot_hour[r_sel] <= w_ed_hour;
            r_slot_min[r_sel]  <= w_ed_min;
            r_slot_ampm[r_sel] <= w_ed_ampm;
         end
         r_to_cnt <= ((r_state == ST_FEED) && (w_nxt_state == ST_FEED)) ? r_to_cnt + TW'(1) : '0;
         if ((r_state == ST_EDIT) && (w_nxt_state == ST_EDIT)) begin
            if (r_blink_cnt == BL_LAST) begin
               r_blink_cnt <= '0;
               r_blink     <= ~r_blink;
            end else begin
               r_blink_cnt <= r_blink_cnt + BW'(1);
            end
         end else begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
         end
         if (w_fault_set)      r_fault <= 1'b1;
         else if (w_fault_clr) r_fault <= 1'b0;
         r_feed_req  <= (w_nxt_state == ST_FEED);
         r_editing   <= (w_nxt_state == ST_EDIT);
         r_disp_hour <= w_disp_hour;
         r_disp_min  <= w_disp_min;
         r_disp_ampm <= w_disp_ampm;
         r_disp_slot <= w_disp_slot;
      end
   end

`ifdef FEED_COUNT_EN
   logic [7:0] r_feed_count;

   // Acked-feed counter, saturating, cleared together with the fault
   always_ff @(posedge clock) begin
      if (reset)                                                          r_feed_count <= 8'd0;
      else if (w_fault_clr)                                               r_feed_count <= 8'd0;
      else if ((r_state == ST_FEED) && feed_ack && (r_feed_count != 8'd255)) r_feed_count <= r_feed_count + 8'd1;
   end

   assign feed_count = r_feed_count;
`endif

   assign disp_hour   = r_disp_hour;
   assign disp_minute = r_disp_min;
   assign disp_ampm   = r_disp_ampm;
   assign disp_slot   = r_disp_slot;
   assign editing     = r_editing;
   assign blink       = r_blink;
   assign feed_req    = r_feed_req;
   assign feed_fault  = r_fault;

endmodule

// File: tb/tb_feed_schedule_ctrl.sv
// Directed plus randomized bench for feed_schedule_ctrl; reference model keeps slots as minutes-of-day.
module tb_feed_schedule_ctrl;
   localparam int NS = 4;
   localparam int BL = 4;
   localparam int TO = 16;
   localparam int M_IDLE = 0, M_BROWSE = 1, M_EDIT = 2, M_FEED = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] cur_hour = 8'd12, cur_minute = 8'd0;
   logic       cur_ampm = 1'b1, min_tick = 1'b0;
   logic       btn_edit = 1'b0, btn_next = 1'b0, btn_hour = 1'b0, btn_min = 1'b0;
   logic       btn_ampm = 1'b0, btn_clear = 1'b0, feed_ack = 1'b0;
   logic [7:0] disp_hour, disp_minute;
   logic       disp_ampm, editing, blink, feed_req, feed_fault;
   logic [2:0] disp_slot;
`ifdef FEED_COUNT_EN
   logic [7:0] feed_count;
`endif

   feed_schedule_ctrl #(.NUM_SLOTS(NS), .BLINK_CYCLES(BL), .ACK_TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_ampm(cur_ampm), .min_tick(min_tick),
      .btn_edit(btn_edit), .btn_next(btn_next), .btn_hour(btn_hour), .btn_min(btn_min),
      .btn_ampm(btn_ampm), .btn_clear(btn_clear), .feed_ack(feed_ack),
      .disp_hour(disp_hour), .disp_minute(disp_minute), .disp_ampm(disp_ampm), .disp_slot(disp_slot),
      .editing(editing), .blink(blink), .feed_req(feed_req),
`ifdef FEED_COUNT_EN
      .feed_count(feed_count),
`endif
      .feed_fault(feed_fault)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: slot = minutes since midnight, -1 when empty
   int m_slot [NS];
   int m_mode, m_sel, m_feed_age, m_edit_age, m_count;
   bit m_fault;
   int e_hour, e_min, e_ampm, e_slot, e_blink;

   function automatic int to_md(int h, int m, int am);
      return (am != 0 ? 0 : 720) + (h % 12) * 60 + m;
   endfunction
   function automatic int hr_of(int md);
      int h = (md / 60) % 12;
      return (h == 0) ? 12 : h;
   endfunction
   function automatic int mn_of(int md);
      return md % 60;
   endfunction
   function automatic int am_of(int md);
      return (md < 720) ? 1 : 0;
   endfunction

   task automatic model_step();
      int cur_md, hit, prev, s;
      prev = m_mode;
      if (reset) begin
         for (int i = 0; i < NS; i++) m_slot[i] = -1;
         m_mode = M_IDLE; m_sel = 0; m_fault = 1'b0; m_count = 0;
         m_feed_age = 0; m_edit_age = 0;
      end else begin
         cur_md = to_md(int'(cur_hour), int'(cur_minute), int'(cur_ampm));
         hit = -1;
         for (int i = NS - 1; i >= 0; i--) if (m_slot[i] == cur_md) hit = i;
         s = m_slot[m_sel];
         if ((m_mode == M_IDLE || m_mode == M_BROWSE) && min_tick && hit >= 0) begin
            m_mode = M_FEED; m_sel = hit; m_feed_age = 0;
         end else if (m_mode == M_IDLE) begin
            if (btn_edit) begin m_mode = M_BROWSE; m_sel = 0; end
            else if (btn_clear) begin m_fault = 1'b0; m_count = 0; end
         end else if (m_mode == M_BROWSE) begin
            if (btn_edit) m_mode = M_EDIT;
            else if (btn_clear) m_slot[m_sel] = -1;
            else if (btn_next) begin
               if (m_sel == NS - 1) begin m_mode = M_IDLE; m_sel = 0; end
               else m_sel++;
            end
         end else if (m_mode == M_EDIT) begin
            if (btn_edit) m_mode = M_BROWSE;
            else if (btn_clear) m_slot[m_sel] = -1;
            else if (btn_next) m_mode = M_EDIT;
            else if (btn_hour)
               m_slot[m_sel] = (s < 0) ? to_md(1, 0, 0)
                             : to_md((hr_of(s) == 12) ? 1 : hr_of(s) + 1, mn_of(s), am_of(s));
            else if (btn_min)
               m_slot[m_sel] = (s < 0) ? to_md(12, 1, 1) : to_md(hr_of(s), (mn_of(s) + 1) % 60, am_of(s));
            else if (btn_ampm)
               m_slot[m_sel] = (s < 0) ? to_md(12, 0, 0) : to_md(hr_of(s), mn_of(s), 1 - am_of(s));
         end else begin
            if (feed_ack) begin
               m_mode = M_IDLE; m_sel = 0;
               if (m_count < 255) m_count++;
            end else begin
               m_feed_age++;
               if (m_feed_age == TO) begin m_mode = M_IDLE; m_sel = 0; m_fault = 1'b1; end
            end
         end
         if (m_mode == M_EDIT) m_edit_age = (prev == M_EDIT) ? m_edit_age + 1 : 0;
      end
      e_hour = int'(cur_hour); e_min = int'(cur_minute); e_ampm = int'(cur_ampm); e_slot = 0;
      if (!reset && (m_mode == M_BROWSE || m_mode == M_EDIT)) begin
         s = m_slot[m_sel];
         e_hour = (s < 0) ? 0 : hr_of(s);
         e_min  = (s < 0) ? 0 : mn_of(s);
         e_ampm = (s < 0) ? 0 : am_of(s);
         e_slot = m_sel;
      end else if (!reset && m_mode == M_FEED) begin
         e_slot = m_sel;
      end
      e_blink = (!reset && m_mode == M_EDIT) ? (m_edit_age / BL) % 2 : 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("disp_hour",   32'(disp_hour),   32'(e_hour));
      chk("disp_minute", 32'(disp_minute), 32'(e_min));
      chk("disp_ampm",   32'(disp_ampm),   32'(e_ampm));
      chk("disp_slot",   32'(disp_slot),   32'(e_slot));
      chk("editing",     32'(editing),     32'(m_mode == M_EDIT && !reset));
      chk("blink",       32'(blink),       32'(e_blink));
      chk("feed_req",    32'(feed_req),    32'(m_mode == M_FEED && !reset));
      chk("feed_fault",  32'(feed_fault),  32'(m_fault));
`ifdef FEED_COUNT_EN
      chk("feed_count",  32'(feed_count),  32'(m_count));
`endif
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      check_all();
      btn_edit = 1'b0; btn_next = 1'b0; btn_hour = 1'b0; btn_min = 1'b0;
      btn_ampm = 1'b0; btn_clear = 1'b0; min_tick = 1'b0;
   endtask

   task automatic set_cur(input int h, input int m, input int am);
      cur_hour = 8'(h); cur_minute = 8'(m); cur_ampm = 1'(am);
   endtask

   initial begin
      int hi, rises, prev_req, r, j;
      // reset
      step(); step();
      reset = 1'b0;
      step();

      // slot 0 -> 7:30 AM through the empty -> 12:01 AM path
      btn_edit = 1'b1; step();
      btn_edit = 1'b1; step();
      repeat (30) begin btn_min = 1'b1; step(); end
      repeat (7) begin btn_hour = 1'b1; step(); end
      chk("a_hour", 32'(disp_hour), 32'd7);
      chk("a_min", 32'(disp_minute), 32'd30);
      chk("a_ampm", 32'(disp_ampm), 32'd1);
      btn_edit = 1'b1; step();
      repeat (4) begin btn_next = 1'b1; step(); end
      chk("a_wrap_slot", 32'(disp_slot), 32'd0);

      // matching tick, ack on the fifth FEED cycle
      set_cur(7, 30, 1); min_tick = 1'b1; step();
      hi = feed_req ? 1 : 0;
      repeat (4) begin step(); if (feed_req) hi++; end
      feed_ack = 1'b1; step(); feed_ack = 1'b0;
      if (feed_req) hi++;
      chk("b_req_cycles", 32'(hi), 32'd5);

      // slots 1 and 2 -> 6:00 PM
      btn_edit = 1'b1; step();
      for (int k = 1; k <= 2; k++) begin
         btn_next = 1'b1; step();
         btn_edit = 1'b1; step();
         btn_ampm = 1'b1; step();
         repeat (6) begin btn_hour = 1'b1; step(); end
         btn_edit = 1'b1; step();
      end
      btn_next = 1'b1; step();
      btn_next = 1'b1; step();
      set_cur(6, 0, 0); min_tick = 1'b1; step();
      chk("c_slot_prio", 32'(disp_slot), 32'd1);
      rises = feed_req ? 1 : 0; prev_req = feed_req ? 1 : 0;
      for (int k = 0; k < 10; k++) begin
         feed_ack = (k == 2) ? 1'b1 : 1'b0;
         step();
         if (feed_req && prev_req == 0) rises++;
         prev_req = feed_req ? 1 : 0;
      end
      feed_ack = 1'b0;
      chk("c_one_req", 32'(rises), 32'd1);

      // slot 3: minute 59 -> 0, hour 12 -> 1, tick in EDIT dropped
      btn_edit = 1'b1; step();
      repeat (3) begin btn_next = 1'b1; step(); end
      btn_edit = 1'b1; step();
      repeat (60) begin btn_min = 1'b1; step(); end
      chk("d_min_wrap", 32'(disp_minute), 32'd0);
      chk("d_min_wrap_hr", 32'(disp_hour), 32'd12);
      btn_hour = 1'b1; step();
      chk("d_hour_wrap", 32'(disp_hour), 32'd1);
      set_cur(1, 0, 1); min_tick = 1'b1; step();
      chk("d_edit_tick", 32'(feed_req), 32'd0);
      btn_edit = 1'b1; step();
      btn_next = 1'b1; step();

      // tick beats btn_edit in IDLE, then timeout
      min_tick = 1'b1; btn_edit = 1'b1; step();
      chk("e_tick_wins", 32'(feed_req), 32'd1);
      chk("e_not_edit", 32'(editing), 32'd0);
      hi = 1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (feed_req) hi++;
         else break;
      end
      chk("e_timeout_len", 32'(hi), 32'(TO));
      chk("e_fault", 32'(feed_fault), 32'd1);
      btn_clear = 1'b1; step();
      chk("e_fault_clr", 32'(feed_fault), 32'd0);

      // reset in FEED
      min_tick = 1'b1; step();
      repeat (3) step();
      reset = 1'b1; set_cur(9, 15, 0); step();
      chk("f_req_drop", 32'(feed_req), 32'd0);
      chk("f_disp_cur", 32'(disp_hour), 32'd9);
      reset = 1'b0;
      btn_edit = 1'b1; step();
      repeat (4) begin btn_next = 1'b1; step(); end

      // randomized phase
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 15);
         case (r)
            0:       btn_edit = 1'b1;
            1:       btn_clear = 1'b1;
            2, 3:    btn_next = 1'b1;
            4, 5, 6: btn_hour = 1'b1;
            7, 8, 9: btn_min = 1'b1;
            10, 11:  btn_ampm = 1'b1;
            default: btn_edit = 1'b0;
         endcase
         if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, 5);
            case (r)
               0: btn_edit = 1'b1;
               1: btn_clear = 1'b1;
               2: btn_next = 1'b1;
               3: btn_hour = 1'b1;
               4: btn_min = 1'b1;
               default: btn_ampm = 1'b1;
            endcase
         end
         min_tick = ($urandom_range(0, 5) == 0);
         j = $urandom_range(0, NS - 1);
         if ($urandom_range(0, 1) == 1 && m_slot[j] >= 0)
            set_cur(hr_of(m_slot[j]), mn_of(m_slot[j]), am_of(m_slot[j]));
         else
            set_cur($urandom_range(1, 12), $urandom_range(0, 59), $urandom_range(0, 1));
         feed_ack = ($urandom_range(0, 5) == 0);
         reset = ($urandom_range(0, 999) == 0);
         step();
      end
      reset = 1'b0; feed_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
